// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LS memory port arbiter.
// State codes, owner codes and the default abort budget.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  localparam int unsigned ARB_TIMEOUT = 255;
  localparam logic [7:0]  IF_WMASK    = 8'hff;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
// On conflict the requester that did not win last time is granted.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
  input  owner_e last_grant,
  output logic   gnt_if,
  output logic   gnt_ls
);

  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    unique case (1'b1)
      if_valid && !ls_valid: gnt_if = 1'b1;
      ls_valid && !if_valid: gnt_ls = 1'b1;
      if_valid && ls_valid: begin
        if (last_grant == OWNER_IF) gnt_ls = 1'b1;
        else                        gnt_if = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences IF and LS onto one memory port, one transaction in flight.
// IDLE grants, ISSUE holds the request, WAIT collects response or aborts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [INST_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              if_rv_q, if_rv_d;
  logic [INST_W-1:0] if_rdata_q, if_rdata_d;
  logic              ls_rv_q, ls_rv_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              err_q, err_d;
  logic              gnt_if, gnt_ls;
  logic              done;
  logic [DATA_W-1:0] rdata_sel;

  rr_arb2 u_rr (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_grant (last_q),
    .gnt_if     (gnt_if),
    .gnt_ls     (gnt_ls)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cnt_d      = cnt_q;
    if_rv_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rv_d    = 1'b0;
    ls_rdata_d = ls_rdata_q;
    err_d      = 1'b0;
    done       = 1'b0;
    rdata_sel  = mem_rdata;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_ls) begin
          owner_d = OWNER_LS;
          last_d  = OWNER_LS;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          state_d = ARB_ISSUE;
        end else if (gnt_if) begin
          owner_d = OWNER_IF;
          last_d  = OWNER_IF;
          addr_d  = if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = IF_WMASK;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready) begin
          state_d = ARB_WAIT;
          cnt_d   = '0;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          done = 1'b1;
        end else if (cnt_q == TO_CNT) begin
          done      = 1'b1;
          rdata_sel = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Stores report zero data; an abort reports zero to either owner.
    if (done) begin
      state_d = ARB_IDLE;
      if (owner_q == OWNER_IF) begin
        if_rv_d    = 1'b1;
        if_rdata_d = rdata_sel[INST_W-1:0];
      end else begin
        ls_rv_d    = 1'b1;
        ls_rdata_d = wen_q ? '0 : rdata_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_IF;
      last_q     <= OWNER_IF;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      if_rv_q    <= 1'b0;
      if_rdata_q <= '0;
      ls_rv_q    <= 1'b0;
      ls_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cnt_q      <= cnt_d;
      if_rv_q    <= if_rv_d;
      if_rdata_q <= if_rdata_d;
      ls_rv_q    <= ls_rv_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
    end
  end

  assign if_req_ready  = (state_q == ARB_IDLE) && gnt_if;
  assign ls_req_ready  = (state_q == ARB_IDLE) && gnt_ls;
  assign mem_req_valid = (state_q == ARB_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_resp_valid = if_rv_q;
  assign if_rdata      = if_rdata_q;
  assign ls_resp_valid = ls_rv_q;
  assign ls_rdata      = ls_rdata_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases
// followed by a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_addr;
  logic        if_resp_valid;
  logic [31:0] if_rdata;
  logic        ls_req_valid, ls_req_ready;
  logic [63:0] ls_addr;
  logic        ls_wen;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_rdata       (if_rdata),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_addr        (ls_addr),
    .ls_wen         (ls_wen),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_rdata       (ls_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic quiet();
    if_req_valid   = 1'b0;
    if_addr        = '0;
    ls_req_valid   = 1'b0;
    ls_addr        = '0;
    ls_wen         = 1'b0;
    ls_wdata       = '0;
    ls_wmask       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    quiet();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Randomized-run model state
  int          ph;
  int          m_last;
  int          m_owner;
  logic [63:0] e_addr, e_wdata;
  logic        e_wen;
  logic [7:0]  e_wmask;
  int          resp_due;
  logic [63:0] resp_data;
  int          dly;
  logic        if_v, ls_v;
  logic [63:0] if_a, ls_a, ls_d;
  logic        ls_w;
  logic [7:0]  ls_m;
  logic        gi, gl;

  initial begin
    int idx;
    int pulses;
    logic found;
    rst = 1'b1;
    quiet();
    do_reset();

    // Reset state
    smp();
    check("rst_rdy", {if_req_ready, ls_req_ready}, 0);
    check("rst_rv", {if_resp_valid, ls_resp_valid, err}, 0);
    check("rst_mreq", mem_req_valid, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    check("rst_mwen_mask", {mem_wen, mem_wmask}, 0);
    check("rst_rdata", ls_rdata | {32'h0, if_rdata}, 0);

    // IF only, memory answers one cycle after request
    tick();
    if_req_valid  = 1'b1;
    if_addr       = 64'h8000_0000;
    mem_req_ready = 1'b1;
    smp();
    check("if_rdy", if_req_ready, 1);
    check("if_lsrdy", ls_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    smp();
    check("if_mreq", mem_req_valid, 1);
    check("if_maddr", mem_addr, 64'h8000_0000);
    check("if_mwen", mem_wen, 0);
    check("if_mmask", mem_wmask, 8'hff);
    check("if_mwdata", mem_wdata, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'hcafe_f00d_0010_0073;
    smp();
    check("if_mreq_off", mem_req_valid, 0);
    check("if_rv_early", if_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    smp();
    check("if_rv", if_resp_valid, 1);
    check("if_rdata", if_rdata, 32'h0010_0073);
    check("if_ls_rv", ls_resp_valid, 0);
    check("if_err", err, 0);
    tick();
    smp();
    check("if_rv_pulse", if_resp_valid, 0);

    // LS store with memory stalling the request
    tick();
    ls_req_valid  = 1'b1;
    ls_addr       = 64'h8000_1000;
    ls_wen        = 1'b1;
    ls_wdata      = 64'h1122_3344_5566_7788;
    ls_wmask      = 8'h0f;
    mem_req_ready = 1'b0;
    smp();
    check("st_rdy", ls_req_ready, 1);
    tick();
    ls_req_valid = 1'b0;
    ls_addr      = '1;
    ls_wdata     = '1;
    ls_wen       = 1'b0;
    ls_wmask     = 8'h55;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      smp();
      check("st_mreq", mem_req_valid, 1);
      check("st_maddr", mem_addr, 64'h8000_1000);
      check("st_mwdata", mem_wdata, 64'h1122_3344_5566_7788);
      check("st_mwen_mask", {mem_wen, mem_wmask}, 9'h10f);
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'hdead_beef_dead_beef;
    smp();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_resp_valid = 1'b0;
      smp();
      if (ls_resp_valid) begin
        pulses++;
        check("st_rdata", ls_rdata, 0);
      end
    end
    check("st_pulses", pulses, 1);

    // Four back-to-back conflicts after reset: LS, IF, LS, IF
    do_reset();
    if_req_valid   = 1'b1;
    if_addr        = 64'h8000_0040;
    ls_req_valid   = 1'b1;
    ls_addr        = 64'h8000_2000;
    ls_wen         = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h0123_4567_89ab_cdef;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("cf_ls", ls_req_ready, (k % 2) == 0);
      check("cf_if", if_req_ready, (k % 2) == 1);
      tick();
      tick();
      tick();
    end
    quiet();
    tick();
    tick();

    // Memory never answers: abort after the wait budget
    tick();
    ls_req_valid  = 1'b1;
    ls_addr       = 64'h8000_3000;
    ls_wen        = 1'b0;
    mem_req_ready = 1'b1;
    mem_rdata     = 64'hffff_0000_ffff_0000;
    smp();
    check("to_rdy", ls_req_ready, 1);
    tick();
    ls_req_valid = 1'b0;
    smp();
    check("to_mreq", mem_req_valid, 1);
    tick();
    mem_req_ready = 1'b0;
    idx   = 0;
    found = 1'b0;
    while (idx < 400 && !found) begin
      smp();
      if (err) found = 1'b1;
      else begin
        idx++;
        tick();
      end
    end
    check("to_seen", found, 1);
    check("to_cycles", idx, TO + 1);
    check("to_lsrv", ls_resp_valid, 1);
    check("to_rdata", ls_rdata, 0);
    check("to_ifrv", if_resp_valid, 0);
    tick();
    ls_req_valid = 1'b1;
    smp();
    check("to_err_pulse", err, 0);
    check("to_idle", ls_req_ready, 1);
    do_reset();

    // Reset during WAIT drops the response
    tick();
    if_req_valid  = 1'b1;
    if_addr       = 64'h8000_0100;
    mem_req_ready = 1'b1;
    smp();
    tick();
    if_req_valid = 1'b0;
    smp();
    tick();
    rst = 1'b1;
    smp();
    tick();
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h1111_2222_3333_4444;
    smp();
    check("rw_rv0", {if_resp_valid, ls_resp_valid}, 0);
    tick();
    mem_resp_valid = 1'b0;
    smp();
    check("rw_rv1", {if_resp_valid, ls_resp_valid, err}, 0);
    tick();
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    ls_addr      = 64'h8000_4000;
    ls_wen       = 1'b0;
    smp();
    check("rw_cf_ls", ls_req_ready, 1);
    check("rw_cf_if", if_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    smp();
    check("rw_maddr", mem_addr, 64'h8000_4000);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h5555_6666_7777_8888;
    smp();
    tick();
    mem_resp_valid = 1'b0;
    smp();
    check("rw_lsrv", ls_resp_valid, 1);
    check("rw_rdata", ls_rdata, 64'h5555_6666_7777_8888);

    // Spurious responses in IDLE and ISSUE
    tick();
    mem_resp_valid = 1'b1;
    mem_req_ready  = 1'b0;
    smp();
    tick();
    smp();
    check("sp_idle_rv", {if_resp_valid, ls_resp_valid, err}, 0);
    check("sp_idle_mreq", mem_req_valid, 0);
    tick();
    if_req_valid = 1'b1;
    if_addr      = 64'h8000_0200;
    smp();
    check("sp_idle_rdy", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    smp();
    tick();
    smp();
    check("sp_iss_mreq", mem_req_valid, 1);
    check("sp_iss_rv", {if_resp_valid, ls_resp_valid, err}, 0);
    tick();
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    smp();
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h0000_0000_abcd_1234;
    smp();
    tick();
    mem_resp_valid = 1'b0;
    smp();
    check("sp_rv", if_resp_valid, 1);
    check("sp_rdata", if_rdata, 32'habcd_1234);

    // Randomized traffic against the model
    do_reset();
    ph       = 0;
    m_last   = 0;
    m_owner  = 0;
    resp_due = 0;
    dly      = 0;
    if_v     = 1'b0;
    ls_v     = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!if_v && ($urandom % 3 == 0)) begin
        if_v = 1'b1;
        if_a = {32'h0, $urandom};
      end
      if (!ls_v && ($urandom % 3 == 0)) begin
        ls_v = 1'b1;
        ls_a = {$urandom, $urandom};
        ls_d = {$urandom, $urandom};
        ls_w = 1'($urandom);
        ls_m = 8'($urandom);
      end
      if_req_valid  = if_v;
      if_addr       = if_a;
      ls_req_valid  = ls_v;
      ls_addr       = ls_a;
      ls_wdata      = ls_d;
      ls_wen        = ls_w;
      ls_wmask      = ls_m;
      mem_req_ready = 1'($urandom);
      mem_rdata     = {$urandom, $urandom};
      if (ph == 2) mem_resp_valid = (dly == 0);
      else         mem_resp_valid = ($urandom % 6 == 0);
      smp();
      gi = (ph == 0) && if_v && (!ls_v || m_last == 1);
      gl = (ph == 0) && ls_v && (!if_v || m_last == 0);
      check("rnd_ifrdy", if_req_ready, gi);
      check("rnd_lsrdy", ls_req_ready, gl);
      check("rnd_mreq", mem_req_valid, ph == 1);
      if (ph == 1) begin
        check("rnd_maddr", mem_addr, e_addr);
        check("rnd_mwdata", mem_wdata, e_wdata);
        check("rnd_mwen_mask", {mem_wen, mem_wmask}, {e_wen, e_wmask});
      end
      check("rnd_ifrv", if_resp_valid, resp_due == 1);
      check("rnd_lsrv", ls_resp_valid, resp_due == 2);
      check("rnd_err", err, 0);
      if (resp_due == 1) check("rnd_ifdata", if_rdata, resp_data);
      if (resp_due == 2) check("rnd_lsdata", ls_rdata, resp_data);
      resp_due = 0;
      if (ph == 0) begin
        if (gi) begin
          ph = 1; m_owner = 1; m_last = 0; if_v = 1'b0;
          e_addr = if_a; e_wdata = '0; e_wen = 1'b0; e_wmask = 8'hff;
        end else if (gl) begin
          ph = 1; m_owner = 2; m_last = 1; ls_v = 1'b0;
          e_addr = ls_a; e_wdata = ls_d; e_wen = ls_w; e_wmask = ls_m;
        end
      end else if (ph == 1) begin
        if (mem_req_ready) begin
          ph  = 2;
          dly = $urandom % 4;
        end
      end else begin
        if (mem_resp_valid) begin
          resp_due = m_owner;
          if (m_owner == 1)  resp_data = {32'h0, mem_rdata[31:0]};
          else if (e_wen)    resp_data = '0;
          else               resp_data = mem_rdata;
          ph = 0;
        end else begin
          dly--;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
